md_window_accumulator: RTL and testbench

- Downstream consumer of the 2-bit blocking-assignment adder stage. It takes that stage's OUT_E sample stream and sums a window of WIN_LEN valid samples.
- Presents the window total to the next stage with a valid/acknowledge handshake.
- Sits between the adder stage and a display/checker stage. It adds sticky overflow and dropped-sample flags.

---
 rtl/md_window_accumulator_pkg.sv | 15 +
 rtl/md_window_accumulator_if.sv | 27 ++
 rtl/md_window_accumulator_sat_adder.sv | 28 ++
 rtl/md_window_accumulator.sv | 107 ++++++++++
 tb/tb_md_window_accumulator.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/md_window_accumulator_pkg.sv
// Shared definitions for the window accumulator: FSM encoding and the
// sample width common with the upstream adder stage.
package md_window_accumulator_pkg;

  // Width of one sample coming from the adder stage's OUT_E.
  localparam int SAMPLE_W = 2;

  // 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/md_window_accumulator_if.sv
// Sample input / result output bundle of the window accumulator.
// master drives samples and acknowledges, slave is the accumulator.
interface md_window_accumulator_if
  import md_window_accumulator_pkg::*;
#(
  parameter int SUM_W = 6
);
  logic [SAMPLE_W-1:0] IN_E;
  logic                IN_VALID;
  logic                IN_START;
  logic                IN_ACK;
  logic [SUM_W-1:0]    OUT_SUM;
  logic                OUT_VALID;
  logic                OUT_BUSY;
  logic                OUT_OVF;
  logic                OUT_DROP;

  modport master (
    output IN_E, IN_VALID, IN_START, IN_ACK,
    input  OUT_SUM, OUT_VALID, OUT_BUSY, OUT_OVF, OUT_DROP
  );

  modport slave (
    input  IN_E, IN_VALID, IN_START, IN_ACK,
    output OUT_SUM, OUT_VALID, OUT_BUSY, OUT_OVF, OUT_DROP
  );
endinterface

// File: rtl/md_window_accumulator_sat_adder.sv
// Unsigned saturating adder: acc + inc, clamped to all-ones on carry-out.
module md_sat_adder
  import md_window_accumulator_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0]        acc,
  input  logic [SAMPLE_W-1:0] inc,
  output logic [W-1:0]        sum,
  output logic                sat
);

  // Returns {saturated, result}; the extra carry bit of the widened add
  // is exactly the overflow indication.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a,
                                         input logic [SAMPLE_W-1:0] b);
    logic [W:0] wide;
    wide = {1'b0, a} + (W+1)'(b);
    if (wide[W]) sat_add = {1'b1, {W{1'b1}}};
    else         sat_add = {1'b0, wide[W-1:0]};
  endfunction

  // Purely combinational; the top registers the result.
  always_comb begin
    {sat, sum} = sat_add(acc, inc);
  end

endmodule

// File: rtl/md_window_accumulator.sv
// Sums WIN_LEN valid samples into a saturating total and holds it for a
// valid/ack consumer. Tracks sticky overflow and dropped-sample flags.
module md_window_accumulator
  import md_window_accumulator_pkg::*;
#(
  parameter int WIN_LEN = 4,
  parameter int SUM_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  md_window_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  // Count value held just before the edge that accepts the final sample.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum_r;
  logic             valid_r;
  logic             busy_r;
  logic             ovf_r;
  logic             drop_r;

  logic [SUM_W-1:0] acc_next;
  logic             acc_sat;

  md_sat_adder #(.W(SUM_W)) u_sat_adder (
    .acc (acc),
    .inc (bus.IN_E),
    .sum (acc_next),
    .sat (acc_sat)
  );

  // Window FSM with accumulator, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      sum_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.IN_START) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf_r   <= 1'b0;
            drop_r  <= 1'b0;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        ST_ACCUM: begin
          // START is deliberately ignored here: a window is never truncated.
          if (bus.IN_VALID) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (acc_sat) ovf_r <= 1'b1;
            if (cnt == LAST_CNT) begin
              sum_r   <= acc_next;
              state   <= ST_DONE;
              busy_r  <= 1'b0;
              valid_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.IN_VALID) drop_r <= 1'b1;
          if (bus.IN_ACK) begin
            valid_r <= 1'b0;
            if (bus.IN_START) begin
              // Back-to-back window: clearing wins over a same-edge drop.
              state  <= ST_ACCUM;
              acc    <= '0;
              cnt    <= '0;
              ovf_r  <= 1'b0;
              drop_r <= 1'b0;
              busy_r <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.OUT_SUM   = sum_r;
  assign bus.OUT_VALID = valid_r;
  assign bus.OUT_BUSY  = busy_r;
  assign bus.OUT_OVF   = ovf_r;
  assign bus.OUT_DROP  = drop_r;

endmodule

// File: tb/tb_md_window_accumulator.sv
// Directed bench: a 6-bit accumulator for the main checks and a 3-bit one
// sharing the same stimulus for saturation.
module tb_md_window_accumulator;
  import md_window_accumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] e;
  logic       vld, start, ack;

  int checks = 0;
  int errors = 0;

  md_window_accumulator_if #(.SUM_W(6)) bus6 ();
  md_window_accumulator_if #(.SUM_W(3)) bus3 ();

  assign bus6.IN_E = e;  assign bus6.IN_VALID = vld;
  assign bus6.IN_START = start;  assign bus6.IN_ACK = ack;
  assign bus3.IN_E = e;  assign bus3.IN_VALID = vld;
  assign bus3.IN_START = start;  assign bus3.IN_ACK = ack;

  md_window_accumulator #(.WIN_LEN(4), .SUM_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  md_window_accumulator #(.WIN_LEN(4), .SUM_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  typedef struct {
    logic       v, s, a;
    logic [1:0] e;
    logic [5:0] sum;
    logic       valid, busy, ovf, drop;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk6(input string tag, input int sum, input int valid,
                      input int busy, input int ovf, input int drop);
    chk({tag, ".sum"},   int'(bus6.OUT_SUM),   sum);
    chk({tag, ".valid"}, int'(bus6.OUT_VALID), valid);
    chk({tag, ".busy"},  int'(bus6.OUT_BUSY),  busy);
    chk({tag, ".ovf"},   int'(bus6.OUT_OVF),   ovf);
    chk({tag, ".drop"},  int'(bus6.OUT_DROP),  drop);
  endtask

  // Inputs are applied on the next rising edge; outputs sampled 1 time unit after it.
  task automatic cyc(input logic v, input logic s, input logic a, input logic [1:0] ev);
    vld = v; start = s; ack = a; e = ev;
    @(posedge clk); #1;
    vld = 1'b0; start = 1'b0; ack = 1'b0; e = 2'd0;
  endtask

  initial begin
    vld = 0; start = 0; ack = 0; e = 0;
    rst = 1'b1;
    #2;
    chk6("reset", 0, 0, 0, 0, 0);
    chk("reset.sum3", int'(bus3.OUT_SUM), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //               v  s  a  e     sum vld busy ovf drop
    tbl[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd3, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 6'd6, 1'b1, 1'b0, 1'b0, 1'b1 ^ 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd3, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].a, tbl[i].e);
      chk6($sformatf("tbl%0d", i), int'(tbl[i].sum), int'(tbl[i].valid),
           int'(tbl[i].busy), int'(tbl[i].ovf), int'(tbl[i].drop));
    end

    // Gapped samples of 3: result only after the 4th valid one.
    cyc(0, 1, 0, 0);
    begin
      logic [5:0] pat;
      pat = 6'b110101;
      for (int i = 0; i < 6; i++) begin
        cyc(pat[i], 0, 0, 2'd3);
        chk($sformatf("gap%0d.valid", i), int'(bus6.OUT_VALID), (i == 5) ? 1 : 0);
      end
    end
    chk("gap.sum", int'(bus6.OUT_SUM), 12);

    // Pending result while samples keep arriving: held, drop flagged.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 2'd2);
      chk($sformatf("hold%0d.sum", i), int'(bus6.OUT_SUM), 12);
      chk($sformatf("hold%0d.valid", i), int'(bus6.OUT_VALID), 1);
    end
    chk("hold.drop", int'(bus6.OUT_DROP), 1);
    cyc(0, 1, 1, 0);
    chk6("ackstart", 12, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2'd1);
    chk6("ackstart.win", 4, 1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Saturation on the 3-bit instance, then cleared by the next START.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2'd3);
    chk("sat.sum3", int'(bus3.OUT_SUM), 7);
    chk("sat.ovf3", int'(bus3.OUT_OVF), 1);
    chk("sat.valid3", int'(bus3.OUT_VALID), 1);
    chk("sat.sum6", int'(bus6.OUT_SUM), 12);
    chk("sat.ovf6", int'(bus6.OUT_OVF), 0);
    cyc(0, 0, 1, 0);
    chk("sat.ovf3_idle", int'(bus3.OUT_OVF), 1);
    cyc(0, 1, 0, 0);
    chk("sat.ovf3_clr", int'(bus3.OUT_OVF), 0);

    // START re-pulsed mid-window does not restart or truncate it.
    cyc(1, 0, 0, 2'd2);
    cyc(1, 0, 0, 2'd1);
    cyc(0, 1, 0, 0);
    chk("restart.busy", int'(bus6.OUT_BUSY), 1);
    cyc(1, 0, 0, 2'd3);
    chk("restart.valid3", int'(bus6.OUT_VALID), 0);
    cyc(1, 0, 0, 2'd0);
    chk6("restart.win", 6, 1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Asynchronous reset in the middle of a window.
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 2'd3);
    cyc(1, 0, 0, 2'd3);
    #2 rst = 1'b1;
    #1;
    chk6("arst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk6("arst.held", 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2'd2);
    chk6("arst.win", 8, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
